// File: rtl/neogeo_bus_pkg.sv
// Shared encodings for the 68000-style bus master: FSM states, default timeout,
// and the byte-enable to active-low data-strobe mapping.
package neogeo_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_LATCH = 3'd3,
    ST_END   = 3'd4
  } bus_state_t;

  localparam int TIMEOUT_CYCLES_DEF = 31;

  localparam logic [1:0] BE_NONE     = 2'b00;
  localparam logic [1:0] BE_BOTH     = 2'b11;
  localparam logic [1:0] STROBES_OFF = 2'b11;

  // Returns {nUDS, nLDS}; an empty byte-enable means a full-word access.
  function automatic logic [1:0] be_to_strobes(input logic [1:0] be);
    return (be == BE_NONE) ? ~BE_BOTH : ~be;
  endfunction

endpackage

// File: rtl/m68k_bus_master.sv
// 68000-style bus initiator: one word per request on nAS/nUDS/nLDS/RW, waits for nDTACK (timeout via M68K_BUS_MASTER_TIMEOUT_EN).
// Latency: REQ accept edge to DONE = 4 clocks plus one per wait clock; timeout ends after TIMEOUT_CYCLES wait clocks.
// Backpressure: REQ sampled only while BUSY=0; the responder stretches the cycle by holding nDTACK high.
module m68k_bus_master
  import neogeo_bus_pkg::*;
#(
  parameter int ADDR_W         = 23,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              CLK_68KCLK,
  input  logic              RESET,
  input  logic              REQ,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [1:0]        REQ_BE,
  input  logic [15:0]       REQ_WDATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [15:0]       RDATA,
  output logic [ADDR_W-1:0] A,
  output logic              RW,
  output logic              nAS,
  output logic              nUDS,
  output logic              nLDS,
  output logic [15:0]       DOUT,
  output logic              DOE,
  input  logic [15:0]       DIN,
  input  logic              nDTACK
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be within 1..255");
  end

  bus_state_t state_q, state_d;
  logic [1:0] be_q;
  logic       timeout_hit;

`ifdef M68K_BUS_MASTER_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_cnt_q;
  logic       err_flag_q;

  // Fires on the wait clock whose increment would reach the limit.
  assign timeout_hit = (8'(wait_cnt_q + 8'd1) == TIMEOUT_LIMIT);

  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) begin
      wait_cnt_q <= 8'd0;
      err_flag_q <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      ERR <= 1'b0;
      case (state_q)
        ST_IDLE:  if (REQ) err_flag_q <= 1'b0;
        ST_ADDR:  wait_cnt_q <= 8'd0;
        ST_WAIT: begin
          if (nDTACK) begin
            if (wait_cnt_q != 8'hFF) wait_cnt_q <= wait_cnt_q + 8'd1;
            if (timeout_hit) err_flag_q <= 1'b1;
          end
        end
        ST_END:   ERR <= err_flag_q;
        default: ;
      endcase
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign ERR         = 1'b0;
`endif

  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // nDTACK takes priority over the timeout when both land on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (REQ) state_d = ST_ADDR;
      ST_ADDR:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (!nDTACK)          state_d = ST_LATCH;
        else if (timeout_hit) state_d = ST_END;
      end
      ST_LATCH: state_d = ST_END;
      ST_END:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_68KCLK) begin
    if (RESET) begin
      BUSY  <= 1'b0;
      DONE  <= 1'b0;
      RDATA <= 16'h0000;
      A     <= '0;
      RW    <= 1'b1;
      nAS   <= 1'b1;
      nUDS  <= 1'b1;
      nLDS  <= 1'b1;
      DOUT  <= 16'h0000;
      DOE   <= 1'b0;
      be_q  <= 2'b00;
    end else begin
      DONE <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (REQ) begin
            A    <= REQ_ADDR;
            RW   <= ~REQ_WE;
            DOUT <= REQ_WDATA;
            be_q <= REQ_BE;
            BUSY <= 1'b1;
          end
        end
        ST_ADDR: begin
          nAS          <= 1'b0;
          {nUDS, nLDS} <= be_to_strobes(be_q);
          DOE          <= ~RW;
        end
        ST_LATCH: if (RW) RDATA <= DIN;
        ST_END: begin
          nAS          <= 1'b1;
          {nUDS, nLDS} <= STROBES_OFF;
          DOE          <= 1'b0;
          RW           <= 1'b1;
          DONE         <= 1'b1;
          BUSY         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
